// File: rtl/bp_ctrl_pkg.sv
// Shared constants, entry layout and compare helpers for the branch-prediction controller.
package bp_ctrl_pkg;
  localparam int INST_ADDR_W = 32;
  localparam logic [INST_ADDR_W-1:0] REDIRECT_OFFSET = 32'h4;
  localparam logic JUMP_ENABLE  = 1'b1;
  localparam logic JUMP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b0;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic                   taken;
    logic [INST_ADDR_W-1:0] target;
  } bp_entry_t;

  localparam int ENTRY_W = $bits(bp_entry_t);

  function automatic logic is_mispredict(bp_entry_t e, logic res_taken,
                                         logic [INST_ADDR_W-1:0] res_addr);
    return (e.taken != res_taken) || (res_taken && (e.target != res_addr));
  endfunction

  // Not-taken falls through to pc+4 and wraps at the top of the address space.
  function automatic logic [INST_ADDR_W-1:0] fix_target(bp_entry_t e, logic res_taken,
                                                        logic [INST_ADDR_W-1:0] res_addr);
    return res_taken ? res_addr : e.pc + REDIRECT_OFFSET;
  endfunction
endpackage

// File: rtl/bp_ctrl_if.sv
// Fetch/execute-facing signal bundle of bp_ctrl; master drives predictions and resolutions.
interface bp_ctrl_if;
  import bp_ctrl_pkg::*;

  logic                   pred_valid_i;
  logic                   pred_taken_i;
  logic [INST_ADDR_W-1:0] pred_pc_i;
  logic [INST_ADDR_W-1:0] pred_addr_i;
  logic                   res_valid_i;
  logic                   res_taken_i;
  logic [INST_ADDR_W-1:0] res_addr_i;
  logic                   hold_i;
  logic                   full_o;
  logic                   jump_flag_o;
  logic [INST_ADDR_W-1:0] jump_addr_o;
  logic                   flush_o;
  logic                   err_o;
  logic [31:0]            perf_res_cnt_o;
  logic [31:0]            perf_mis_cnt_o;

  modport master (
    output pred_valid_i, pred_taken_i, pred_pc_i, pred_addr_i,
    output res_valid_i, res_taken_i, res_addr_i, hold_i,
    input  full_o, jump_flag_o, jump_addr_o, flush_o, err_o,
    input  perf_res_cnt_o, perf_mis_cnt_o
  );

  modport slave (
    input  pred_valid_i, pred_taken_i, pred_pc_i, pred_addr_i,
    input  res_valid_i, res_taken_i, res_addr_i, hold_i,
    output full_o, jump_flag_o, jump_addr_o, flush_o, err_o,
    output perf_res_cnt_o, perf_mis_cnt_o
  );
endinterface

// File: rtl/bp_ctrl_fifo.sv
// bp_fifo: synchronous FIFO with pointer flush; wr_vld/rd_vld must already be qualified by
// the caller (no write when full unless reading, no read when empty). Read data is combinational.
module bp_fifo
  import bp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + PW'(1);
      if (rd_vld) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld && !flush) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  // Extra MSB distinguishes a wrapped (full) queue from an empty one.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign rd_dat = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/bp_ctrl.sv
// Branch-prediction controller: in-order prediction queue, mispredict redirect/flush one cycle
// after resolution, fetch back-pressure via full_o. Perf counters built only with BP_PERF_CNT_EN.
module bp_ctrl
  import bp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  bp_ctrl_if.slave bus
);
  logic [0:0]         state;
  logic [ENTRY_W-1:0] rd_dat;
  bp_entry_t          head;
  bp_entry_t          new_ent;
  logic               full;
  logic               empty;
  logic               idle;
  logic               pop;
  logic               push;
  logic               mis;
  logic               err_cond;
  logic [INST_ADDR_W-1:0] jump_addr;
  logic               err;

  assign idle = (state == ST_IDLE);
  assign head = rd_dat;
  assign new_ent = '{pc: bus.pred_pc_i, taken: bus.pred_taken_i, target: bus.pred_addr_i};

  assign pop  = bus.res_valid_i & ~bus.hold_i & ~empty & idle;
  assign mis  = pop & is_mispredict(head, bus.res_taken_i, bus.res_addr_i);
  // A push in the mispredict cycle belongs to the wrong path and is dropped.
  assign push = bus.pred_valid_i & ~bus.hold_i & idle & (~full | pop) & ~mis;

  assign err_cond = ~bus.hold_i & idle &
                    ((bus.res_valid_i & empty) | (bus.pred_valid_i & full & ~pop));

  bp_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (mis),
    .wr_vld (push),
    .wr_dat (new_ent),
    .rd_vld (pop),
    .rd_dat (rd_dat),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_IDLE;
      jump_addr <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mis) begin
            state     <= ST_REDIRECT;
            jump_addr <= fix_target(head, bus.res_taken_i, bus.res_addr_i);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (err_cond) err <= 1'b1;
    end
  end

  assign bus.full_o      = full;
  assign bus.jump_flag_o = (state == ST_REDIRECT) ? JUMP_ENABLE : JUMP_DISABLE;
  assign bus.flush_o     = (state == ST_REDIRECT);
  assign bus.jump_addr_o = jump_addr;
  assign bus.err_o       = err;

`ifdef BP_PERF_CNT_EN
  logic [31:0] res_cnt;
  logic [31:0] mis_cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      res_cnt <= '0;
      mis_cnt <= '0;
    end else begin
      if (pop) res_cnt <= res_cnt + 32'd1;
      if (mis) mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign bus.perf_res_cnt_o = res_cnt;
  assign bus.perf_mis_cnt_o = mis_cnt;
`else
  assign bus.perf_res_cnt_o = 32'h0;
  assign bus.perf_mis_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_bp_ctrl.sv
// Directed bench for bp_ctrl: queue-level reference model checked every cycle plus literal pins.
module tb_bp_ctrl;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  bp_ctrl_if bus();

  bp_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_jump;
  logic [31:0] m_addr;
  bit          m_err;
  int unsigned m_res;
  int unsigned m_mis;

  function automatic logic [31:0] exp_cnt(int unsigned v);
`ifdef BP_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of predictions updated from the rules on each edge.
  always @(posedge clk) begin : model
    bit     nj;
    bit     did_pop;
    bit     was_full;
    bit     wrong;
    m_ent_t h;
    if (!rst) begin
      mq.delete();
      m_jump = 0;
      m_addr = 32'h0;
      m_err  = 0;
      m_res  = 0;
      m_mis  = 0;
    end else begin
      nj = 0;
      if (!m_jump && !bus.hold_i) begin
        did_pop  = bus.res_valid_i && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        wrong    = 0;
        if (bus.res_valid_i && mq.size() == 0) m_err = 1;
        if (bus.pred_valid_i && was_full && !did_pop) m_err = 1;
        if (did_pop) begin
          h = mq.pop_front();
          m_res++;
          wrong = (h.taken != bus.res_taken_i) || (bus.res_taken_i && h.tgt != bus.res_addr_i);
          if (wrong) begin
            m_mis++;
            m_addr = bus.res_taken_i ? bus.res_addr_i : h.pc + 32'd4;
            nj = 1;
            mq.delete();
          end
        end
        if (bus.pred_valid_i && !wrong && (!was_full || did_pop))
          mq.push_back('{pc: bus.pred_pc_i, taken: bus.pred_taken_i, tgt: bus.pred_addr_i});
      end
      m_jump = nj;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_full",  {31'h0, bus.full_o},      {31'h0, mq.size() == DEPTH});
      chk("cyc_jump",  {31'h0, bus.jump_flag_o}, {31'h0, m_jump});
      chk("cyc_flush", {31'h0, bus.flush_o},     {31'h0, m_jump});
      chk("cyc_addr",  bus.jump_addr_o,          m_addr);
      chk("cyc_err",   {31'h0, bus.err_o},       {31'h0, m_err});
      chk("cyc_rcnt",  bus.perf_res_cnt_o,       exp_cnt(m_res));
      chk("cyc_mcnt",  bus.perf_mis_cnt_o,       exp_cnt(m_mis));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.pred_valid_i = 0; bus.pred_taken_i = 0; bus.pred_pc_i = 0; bus.pred_addr_i = 0;
    bus.res_valid_i  = 0; bus.res_taken_i  = 0; bus.res_addr_i = 0;
  endtask

  task automatic drive_pred(logic [31:0] pc, logic taken, logic [31:0] tgt);
    bus.pred_valid_i = 1; bus.pred_pc_i = pc; bus.pred_taken_i = taken; bus.pred_addr_i = tgt;
  endtask

  task automatic drive_res(logic taken, logic [31:0] addr);
    bus.res_valid_i = 1; bus.res_taken_i = taken; bus.res_addr_i = addr;
  endtask

  initial begin
    rst = 0;
    bus.hold_i = 0;
    idle_in();
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_jump", {31'h0, bus.jump_flag_o}, 32'h0);
    chk("rst_addr", bus.jump_addr_o, 32'h0);
    chk("rst_err",  {31'h0, bus.err_o}, 32'h0);
    chk("rst_full", {31'h0, bus.full_o}, 32'h0);
    chk("rst_rcnt", bus.perf_res_cnt_o, 32'h0);
    rst = 1;

    // Correct taken prediction pops silently.
    drive_pred(32'h100, 1, 32'h140); cyc(); idle_in();
    drive_res(1, 32'h140); cyc(); idle_in();
    chk("t1_jump", {31'h0, bus.jump_flag_o}, 32'h0);
    chk("t1_rcnt", bus.perf_res_cnt_o, exp_cnt(1));
    chk("t1_mcnt", bus.perf_mis_cnt_o, exp_cnt(0));

    // Direction mispredict; a push in the same cycle is discarded.
    drive_pred(32'h200, 0, 32'h0); cyc(); idle_in();
    drive_res(1, 32'h1F0); drive_pred(32'h300, 1, 32'h300); cyc(); idle_in();
    chk("t2_jump",  {31'h0, bus.jump_flag_o}, 32'h1);
    chk("t2_flush", {31'h0, bus.flush_o}, 32'h1);
    chk("t2_addr",  bus.jump_addr_o, 32'h1F0);
    chk("t2_full",  {31'h0, bus.full_o}, 32'h0);
    cyc();
    chk("t2_jump_end", {31'h0, bus.jump_flag_o}, 32'h0);

    // Not-taken correction wraps pc+4 to zero.
    drive_pred(32'hFFFF_FFFC, 1, 32'h10); cyc(); idle_in();
    drive_res(0, 32'h0); cyc(); idle_in();
    chk("t3_jump", {31'h0, bus.jump_flag_o}, 32'h1);
    chk("t3_addr", bus.jump_addr_o, 32'h0);
    chk("t3_mcnt", bus.perf_mis_cnt_o, exp_cnt(2));
    chk("t3_rcnt", bus.perf_res_cnt_o, exp_cnt(3));
    cyc();

    // Fill, overflow push, push+pop while full, drain.
    for (int i = 0; i < DEPTH; i++) begin
      drive_pred(32'h400 + 32'(i) * 32'h10, 0, 32'h0); cyc();
    end
    idle_in();
    chk("t4_full", {31'h0, bus.full_o}, 32'h1);
    chk("t4_err0", {31'h0, bus.err_o}, 32'h0);
    drive_pred(32'h500, 0, 32'h0); cyc(); idle_in();
    chk("t4_err1", {31'h0, bus.err_o}, 32'h1);
    drive_pred(32'h510, 0, 32'h0); drive_res(0, 32'h0); cyc(); idle_in();
    chk("t4_full_pp", {31'h0, bus.full_o}, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      drive_res(0, 32'h0); cyc();
    end
    idle_in();
    chk("t4_drained", {31'h0, bus.full_o}, 32'h0);
    chk("t4_rcnt", bus.perf_res_cnt_o, exp_cnt(8));
    rst = 0; cyc(); rst = 1;
    chk("t4_rst_err",  {31'h0, bus.err_o}, 32'h0);
    chk("t4_rst_rcnt", bus.perf_res_cnt_o, 32'h0);
    chk("t4_rst_mcnt", bus.perf_mis_cnt_o, 32'h0);

    // Resolve on empty queue.
    drive_res(1, 32'h40); cyc(); idle_in();
    chk("t5_err",  {31'h0, bus.err_o}, 32'h1);
    chk("t5_jump", {31'h0, bus.jump_flag_o}, 32'h0);
    rst = 0; cyc(); rst = 1;

    // Target mispredict, hold during the redirect cycle.
    drive_pred(32'h600, 1, 32'h700); cyc(); idle_in();
    drive_res(1, 32'h704); cyc(); idle_in();
    bus.hold_i = 1; drive_pred(32'h990, 0, 32'h0); #1;
    chk("t6_jump", {31'h0, bus.jump_flag_o}, 32'h1);
    chk("t6_addr", bus.jump_addr_o, 32'h704);
    cyc(); idle_in();
    chk("t6_jump_end", {31'h0, bus.jump_flag_o}, 32'h0);
    bus.hold_i = 0;
    drive_pred(32'h800, 0, 32'h0); cyc(); idle_in();
    bus.hold_i = 1; drive_res(1, 32'h900); drive_pred(32'h880, 0, 32'h0); cyc(); cyc();
    chk("t6_hold_jump", {31'h0, bus.jump_flag_o}, 32'h0);
    chk("t6_hold_rcnt", bus.perf_res_cnt_o, exp_cnt(1));
    chk("t6_hold_mcnt", bus.perf_mis_cnt_o, exp_cnt(1));
    bus.hold_i = 0; idle_in();
    drive_res(0, 32'h0); cyc(); idle_in();
    chk("t6_pop_jump", {31'h0, bus.jump_flag_o}, 32'h0);
    chk("t6_pop_rcnt", bus.perf_res_cnt_o, exp_cnt(2));

    // Reset in the middle of a redirect.
    drive_pred(32'hA00, 0, 32'h0); cyc(); idle_in();
    drive_res(1, 32'hB00); cyc(); idle_in();
    chk("t7_jump", {31'h0, bus.jump_flag_o}, 32'h1);
    rst = 0; cyc(); rst = 1;
    chk("t7_rst_jump",  {31'h0, bus.jump_flag_o}, 32'h0);
    chk("t7_rst_flush", {31'h0, bus.flush_o}, 32'h0);
    chk("t7_rst_addr",  bus.jump_addr_o, 32'h0);
    chk("t7_rst_rcnt",  bus.perf_res_cnt_o, 32'h0);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
